// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one byte-wide memory port (20-bit address, 8-bit data) between the
//   CPU core and a DMA/video requester, using round-robin arbitration.
//   A CPU request carries a segment:offset address and may be a byte or a
//   16-bit word. A word is split into two byte cycles, low byte first. A DMA
//   request is always a single byte at a physical address.
//
// Ports
//   clock, reset_n                : clock (rising edge) and async active-low reset
//   cpu_req/we/word/seg/off/wdata : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack            : CPU read data (valid with ack), 1-cycle ack pulse
//   dma_req/we/addr/wdata         : DMA request, held until dma_ack
//   dma_rdata, dma_ack            : DMA read byte (valid with ack), 1-cycle ack pulse
//   address, out, wren            : memory address, write data and write enable (registered)
//   data                          : memory read data, valid one cycle after its address
module mem_bus_arbiter #(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_word,
  input  logic [15:0] cpu_seg,
  input  logic [15:0] cpu_off,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [19:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [19:0] address,
  input  logic [7:0]  data,
  output logic [7:0]  out,
  output logic        wren
);

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t      state, state_nxt;
  logic        prio, prio_nxt;           // 1: DMA wins the next tie
  logic        gnt_dma, gnt_dma_nxt;
  logic        op_we, op_we_nxt;
  logic        op_word, op_word_nxt;
  logic [19:0] addr_lo, addr_lo_nxt;
  logic [19:0] addr_hi, addr_hi_nxt;
  logic [15:0] op_wdata, op_wdata_nxt;
  logic [19:0] address_nxt;
  logic [7:0]  out_nxt;
  logic        wren_nxt;
  logic        cpu_ack_nxt, dma_ack_nxt;
  logic [15:0] cpu_rdata_nxt;
  logic [7:0]  dma_rdata_nxt;
  logic        cpu_vld, dma_vld, pick_dma;

  // Real-mode style translation; the 20-bit result wraps naturally.
  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'b0000} + {4'b0000, off};
  endfunction

  // A requester whose ack is high this cycle is still holding its old
  // request, so it must not be granted again.
  assign cpu_vld  = cpu_req & ~cpu_ack;
  assign dma_vld  = dma_req & ~dma_ack;
  assign pick_dma = dma_vld & (~cpu_vld | prio);

  always_comb begin
    state_nxt     = state;
    prio_nxt      = prio;
    gnt_dma_nxt   = gnt_dma;
    op_we_nxt     = op_we;
    op_word_nxt   = op_word;
    addr_lo_nxt   = addr_lo;
    addr_hi_nxt   = addr_hi;
    op_wdata_nxt  = op_wdata;
    address_nxt   = address;
    out_nxt       = out;
    wren_nxt      = wren;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    dma_rdata_nxt = dma_rdata;

    case (state)
      IDLE: begin
        if (cpu_vld || dma_vld) begin
          gnt_dma_nxt = pick_dma;
          prio_nxt    = ~pick_dma;
          if (pick_dma) begin
            op_we_nxt    = dma_we;
            op_word_nxt  = 1'b0;
            addr_lo_nxt  = dma_addr;
            addr_hi_nxt  = dma_addr;
            op_wdata_nxt = {8'h00, dma_wdata};
          end else begin
            op_we_nxt    = cpu_we;
            op_word_nxt  = cpu_word;
            addr_lo_nxt  = phys_addr(cpu_seg, cpu_off);
            // Offset wraps inside the segment before translation.
            addr_hi_nxt  = phys_addr(cpu_seg, cpu_off + 16'd1);
            op_wdata_nxt = cpu_wdata;
          end
          address_nxt = addr_lo_nxt;
          wren_nxt    = op_we_nxt;
          out_nxt     = op_wdata_nxt[7:0];
          state_nxt   = LO;
        end
      end
      LO: begin
        if (op_word) begin
          address_nxt = addr_hi;
          wren_nxt    = op_we;
          out_nxt     = op_wdata[15:8];
          state_nxt   = HI;
        end else begin
          wren_nxt    = 1'b0;
          state_nxt   = FIN;
        end
      end
      HI: begin
        wren_nxt = 1'b0;
        // Memory now returns the low byte addressed during LO.
        if (!op_we && !gnt_dma) cpu_rdata_nxt[7:0] = data;
        state_nxt = FIN;
      end
      FIN: begin
        if (!op_we) begin
          if (gnt_dma)      dma_rdata_nxt       = data;
          else if (op_word) cpu_rdata_nxt[15:8] = data;
          else              cpu_rdata_nxt       = {8'h00, data};
        end
        cpu_ack_nxt = ~gnt_dma;
        dma_ack_nxt = gnt_dma;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prio      <= RESET_PRIO;
      gnt_dma   <= 1'b0;
      op_we     <= 1'b0;
      op_word   <= 1'b0;
      addr_lo   <= '0;
      addr_hi   <= '0;
      op_wdata  <= '0;
      address   <= '0;
      out       <= '0;
      wren      <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      gnt_dma   <= gnt_dma_nxt;
      op_we     <= op_we_nxt;
      op_word   <= op_word_nxt;
      addr_lo   <= addr_lo_nxt;
      addr_hi   <= addr_hi_nxt;
      op_wdata  <= op_wdata_nxt;
      address   <= address_nxt;
      out       <= out_nxt;
      wren      <= wren_nxt;
      cpu_ack   <= cpu_ack_nxt;
      dma_ack   <= dma_ack_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dma_rdata <= dma_rdata_nxt;
    end
  end

endmodule
